// File: rtl/oc8051_wbi_rom_responder.sv
// Wishbone classic responder for the oc8051 instruction port: assembles 32-bit
// instruction words from four reads of an 8-bit synchronous ROM.
module oc8051_wbi_rom_responder #(
  parameter int unsigned ROM_BYTES  = 4096,
  parameter int unsigned EXTRA_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] wbi_adr_i,
  input  logic        wbi_cyc_i,
  input  logic        wbi_stb_i,
  output logic [31:0] wbi_dat_o,
  output logic        wbi_ack_o,
  output logic        wbi_err_o,
  output logic        rom_en_o,
  output logic [15:0] rom_addr_o,
  input  logic [7:0]  rom_data_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT,
    S_ACK,
    S_ERR
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'((EXTRA_WAIT == 0) ? 0 : EXTRA_WAIT - 1);

  state_t      state_reg, state_next;
  logic [15:0] addr_reg;
  logic [1:0]  k_reg;
  logic [3:0]  wait_reg;
  logic        ack_reg, ack_next;
  logic        err_reg, err_next;
  logic        cap_en;
  logic [1:0]  cap_lane;
  logic        req;
  logic [3:0]  oob;

  // While ack/err is still being presented the master may not have dropped stb yet.
  assign req = wbi_cyc_i & wbi_stb_i & ~ack_reg & ~err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_range
      logic [15:0] byte_addr;
      assign byte_addr = wbi_adr_i + 16'(gi);
      assign oob[gi]   = {16'd0, byte_addr} >= ROM_BYTES;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    cap_en     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req) state_next = (|oob) ? S_ERR : S_FETCH;
      end
      S_FETCH: begin
        if (!wbi_cyc_i) begin
          state_next = S_IDLE;
        end else begin
          // Data for byte k-1 arrives during FETCH k.
          cap_en = (k_reg != 2'd0);
          if (k_reg == 2'd3) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!wbi_cyc_i) begin
          state_next = S_IDLE;
        end else begin
          cap_en = 1'b1;
          if (EXTRA_WAIT == 0) begin
            state_next = S_ACK;
            ack_next   = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wbi_cyc_i) begin
          state_next = S_IDLE;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = S_ACK;
          ack_next   = 1'b1;
        end
      end
      S_ACK: state_next = S_IDLE;
      S_ERR: begin
        state_next = S_IDLE;
        err_next   = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // k wraps to 0 on entry to DRAIN, so k-1 selects lane 3 there.
  assign cap_lane = k_reg - 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
      k_reg    <= '0;
      wait_reg <= '0;
      ack_reg  <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      ack_reg <= ack_next;
      err_reg <= err_next;
      if (state_reg == S_IDLE && req) addr_reg <= wbi_adr_i;
      if (state_reg == S_FETCH) begin
        k_reg <= k_reg + 2'd1;
      end else if (state_reg == S_IDLE) begin
        k_reg <= '0;
      end
      if (state_reg == S_WAIT) begin
        wait_reg <= wait_reg + 4'd1;
      end else begin
        wait_reg <= '0;
      end
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] byte_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          byte_reg <= '0;
        end else if (cap_en && cap_lane == 2'(gi)) begin
          byte_reg <= rom_data_i;
        end
      end
      assign wbi_dat_o[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  assign wbi_ack_o  = ack_reg;
  assign wbi_err_o  = err_reg;
  assign rom_en_o   = (state_reg == S_FETCH);
  assign rom_addr_o = rom_en_o ? (addr_reg + {14'd0, k_reg}) : 16'd0;
  assign busy_o     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_oc8051_wbi_rom_responder.sv
// Bench for oc8051_wbi_rom_responder: two instances (4 KiB/no wait, 64 KiB/3 waits)
// with table-driven fetches plus abort, wrap and mid-transaction reset sequences.
module tb_oc8051_wbi_rom_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] adr [2];
  logic        cyc [2];
  logic        stb [2];

  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b, err_a, err_b, en_a, en_b, busy_a, busy_b;
  logic [15:0] raddr_a, raddr_b;
  logic [7:0]  rq_a, rq_b;

  logic [31:0] dat [2];
  logic        ack [2];
  logic        err [2];
  logic        rom_en [2];
  logic        busy [2];
  logic [15:0] rom_addr [2];

  logic [7:0] rom [65536];

  oc8051_wbi_rom_responder #(.ROM_BYTES(4096), .EXTRA_WAIT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wbi_adr_i(adr[0]), .wbi_cyc_i(cyc[0]), .wbi_stb_i(stb[0]),
    .wbi_dat_o(dat_a), .wbi_ack_o(ack_a), .wbi_err_o(err_a), .rom_en_o(en_a),
    .rom_addr_o(raddr_a), .rom_data_i(rq_a), .busy_o(busy_a)
  );

  oc8051_wbi_rom_responder #(.ROM_BYTES(65536), .EXTRA_WAIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .wbi_adr_i(adr[1]), .wbi_cyc_i(cyc[1]), .wbi_stb_i(stb[1]),
    .wbi_dat_o(dat_b), .wbi_ack_o(ack_b), .wbi_err_o(err_b), .rom_en_o(en_b),
    .rom_addr_o(raddr_b), .rom_data_i(rq_b), .busy_o(busy_b)
  );

  always @(posedge clk) begin
    if (en_a) rq_a <= rom[raddr_a];
    if (en_b) rq_b <= rom[raddr_b];
  end

  always_comb begin
    dat[0] = dat_a;   dat[1] = dat_b;
    ack[0] = ack_a;   ack[1] = ack_b;
    err[0] = err_a;   err[1] = err_b;
    rom_en[0] = en_a; rom_en[1] = en_b;
    busy[0] = busy_a; busy[1] = busy_b;
    rom_addr[0] = raddr_a; rom_addr[1] = raddr_b;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Runs one request; idx is the negedge (cycles after E0) at which ack/err was seen.
  task automatic fetch(input int d, input logic [15:0] a, output int idx, output logic got_ack,
                       output logic got_err, output int en_cnt, output logic [63:0] seq,
                       output logic post_term);
    idx = 0; got_ack = 0; got_err = 0; en_cnt = 0; seq = '0; post_term = 0;
    @(negedge clk);
    adr[d] = a; cyc[d] = 1'b1; stb[d] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) adr[d] = a ^ 16'h0F0F;
      if (rom_en[d]) begin
        en_cnt++;
        seq = {seq[47:0], rom_addr[d]};
      end
      if (ack[d] || err[d]) begin
        idx = n; got_ack = ack[d]; got_err = err[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(negedge clk);
    post_term = ack[d] | err[d];
  endtask

  typedef struct {
    logic [15:0] adr;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int idx, en_cnt;
    logic got_ack, got_err, post;
    logic [63:0] seq;
    bit found;

    vecs[0] = '{16'h0010, 1'b0, 32'h78563412};
    vecs[1] = '{16'h0020, 1'b0, 32'hEFBEADDE};
    vecs[2] = '{16'h0100, 1'b0, 32'hA6A7A4A5};
    vecs[3] = '{16'h0FFC, 1'b0, 32'h5A5B5859};
    vecs[4] = '{16'h0FFD, 1'b1, 32'h5A5B5859};
    vecs[5] = '{16'h0FFE, 1'b1, 32'h5A5B5859};
    vecs[6] = '{16'h1000, 1'b1, 32'h5A5B5859};
    vecs[7] = '{16'hFFFE, 1'b1, 32'h5A5B5859};
    vecs[8] = '{16'h0003, 1'b0, 32'hA3A0A1A6};
    vecs[9] = '{16'h0FFF, 1'b1, 32'hA3A0A1A6};

    for (int i = 0; i < 65536; i++) rom[i] = 8'(i) ^ 8'hA5;
    rom[16'h0010] = 8'h12; rom[16'h0011] = 8'h34; rom[16'h0012] = 8'h56; rom[16'h0013] = 8'h78;
    rom[16'h0020] = 8'hDE; rom[16'h0021] = 8'hAD; rom[16'h0022] = 8'hBE; rom[16'h0023] = 8'hEF;
    rom[16'hFFFE] = 8'hA1; rom[16'hFFFF] = 8'hB2; rom[16'h0000] = 8'hC3; rom[16'h0001] = 8'hD4;

    for (int d = 0; d < 2; d++) begin
      adr[d] = '0; cyc[d] = 1'b0; stb[d] = 1'b0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_dat", 64'(dat[d]), 64'(0));
      check("rst_ackerr", 64'({ack[d], err[d]}), 64'(0));
      check("rst_rom", 64'({rom_en[d], rom_addr[d]}), 64'(0));
      check("rst_busy", 64'(busy[d]), 64'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Table: 4 KiB ROM, no extra wait.
    for (int i = 0; i < 10; i++) begin
      logic [15:0] a;
      a = vecs[i].adr;
      fetch(0, a, idx, got_ack, got_err, en_cnt, seq, post);
      $display("vec %0d adr=%h ack=%b err=%b lat=%0d dat=%h", i, a, got_ack, got_err, idx, dat[0]);
      check("v_err", 64'(got_err), 64'(vecs[i].exp_err));
      check("v_ack", 64'(got_ack), 64'(!vecs[i].exp_err));
      check("v_lat", 64'(idx), 64'(vecs[i].exp_err ? 2 : 6));
      check("v_en_cycles", 64'(en_cnt), 64'(vecs[i].exp_err ? 0 : 4));
      check("v_pulse", 64'(post), 64'(0));
      check("v_dat", 64'(dat[0]), 64'(vecs[i].exp_dat));
      if (!vecs[i].exp_err)
        check("v_seq", seq, {a, a + 16'd1, a + 16'd2, a + 16'd3});
    end

    // Three extra wait states.
    fetch(1, 16'h0010, idx, got_ack, got_err, en_cnt, seq, post);
    $display("wait3 adr=0010 ack=%b err=%b lat=%0d dat=%h", got_ack, got_err, idx, dat[1]);
    check("w3_ack", 64'({got_ack, got_err}), 64'(2'b10));
    check("w3_lat", 64'(idx), 64'(9));
    check("w3_en_cycles", 64'(en_cnt), 64'(4));
    check("w3_pulse", 64'(post), 64'(0));
    check("w3_dat", 64'(dat[1]), 64'(32'h78563412));

    // Address wrap on a full 64 KiB ROM.
    fetch(1, 16'hFFFE, idx, got_ack, got_err, en_cnt, seq, post);
    $display("wrap adr=FFFE ack=%b err=%b lat=%0d dat=%h", got_ack, got_err, idx, dat[1]);
    check("wrap_ack", 64'({got_ack, got_err}), 64'(2'b10));
    check("wrap_seq", seq, 64'h FFFE_FFFF_0000_0001);
    check("wrap_dat", 64'(dat[1]), 64'(32'hD4C3B2A1));

    // Abort during FETCH k=2.
    @(negedge clk);
    adr[0] = 16'h0100; cyc[0] = 1'b1; stb[0] = 1'b1;
    found = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rom_en[0] && rom_addr[0] == 16'h0102) begin
        found = 1;
        break;
      end
    end
    check("abort_reach_k2", 64'(found), 64'(1));
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'({busy[0], rom_en[0]}), 64'(0));
    begin
      logic seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
        seen = seen | ack[0] | err[0];
        @(negedge clk);
      end
      check("abort_no_term", 64'(seen), 64'(0));
    end
    $display("abort adr=0100 dat=%h", dat[0]);
    check("abort_lane0", 64'(dat[0][7:0]), 64'(8'hA5));
    check("abort_lane3", 64'(dat[0][31:24]), 64'(8'hA3));
    fetch(0, 16'h0020, idx, got_ack, got_err, en_cnt, seq, post);
    $display("post_abort adr=0020 ack=%b err=%b lat=%0d dat=%h", got_ack, got_err, idx, dat[0]);
    check("pa_ack", 64'({got_ack, got_err}), 64'(2'b10));
    check("pa_lat", 64'(idx), 64'(6));
    check("pa_dat", 64'(dat[0]), 64'(32'hEFBEADDE));

    // Reset asserted during WAIT.
    @(negedge clk);
    adr[1] = 16'h0010; cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (7) @(negedge clk);
    check("mid_in_wait", 64'({busy[1], rom_en[1], ack[1]}), 64'(3'b100));
    rst_n = 1'b0;
    #1;
    check("mid_rst_dat", 64'(dat[1]), 64'(0));
    check("mid_rst_ctl", 64'({ack[1], err[1], rom_en[1], busy[1], rom_addr[1]}), 64'(0));
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(1, 16'h0020, idx, got_ack, got_err, en_cnt, seq, post);
    $display("post_reset adr=0020 ack=%b err=%b lat=%0d dat=%h", got_ack, got_err, idx, dat[1]);
    check("pr_ack", 64'({got_ack, got_err}), 64'(2'b10));
    check("pr_lat", 64'(idx), 64'(9));
    check("pr_dat", 64'(dat[1]), 64'(32'hEFBEADDE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
